pipeline_hazard_controller: RTL and testbench

- Sequencing controller for the 5-stage integer pipeline (IF, ID, EX, MEM, WB).
- Tracks the destination/control bits of in-flight instructions in its own EX/MEM/WB shadow slots, fed from the decode-stage control signals.
- Generates stall, flush, bubble and forwarding selects for the pipeline registers.
- Owns the D-cache request handshake and freezes the pipeline while a load/store waits.

---
 rtl/pipeline_hazard_controller.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the 5-stage integer pipeline.
// Keeps EX/MEM/WB shadow slots of in-flight control bits. It drives the stall,
// flush, bubble and freeze controls, the EX forwarding selects and the D-cache
// request handshake.
// Build option: define FORWARDING_EN to enable EX operand forwarding. When it is
// undefined, every EX/MEM dependency is resolved by stalling ID.
//
// D-cache FSM
//   state   | meaning
//   ST_IDLE | no access outstanding, or the access in MEM completes this cycle
//   ST_WAIT | access in MEM still waiting for dmem_ack, pipeline frozen
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  ex_redirect,
  input  logic                  dmem_ack,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_ex,
  output logic                  freeze,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  dmem_req,
  output logic                  mem_timeout
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_acc;
  } slot_t;

  typedef enum logic {ST_IDLE, ST_WAIT} dstate_t;

  localparam slot_t BUBBLE = '0;

  slot_t      id_slot, ex_q, mem_q, wb_q;
  dstate_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       timeout_d;
  logic       data_stall, redirect, hz_stall;
  logic       unused_slot_bits;

  // x0 never matches; the slot must be a valid register writer
  function automatic logic hit(input slot_t s, input logic [REG_ADDR_W-1:0] src,
                               input logic use_src);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == src) && use_src;
  endfunction

  // Source fields are zeroed when unused so a zero index can never forward later
  always_comb begin
    id_slot = BUBBLE;
    if (id_valid) begin
      id_slot.valid     = 1'b1;
      id_slot.rd        = id_rd;
      id_slot.rs1       = id_use_rs1 ? id_rs1 : '0;
      id_slot.rs2       = id_use_rs2 ? id_rs2 : '0;
      id_slot.reg_write = id_reg_write;
      id_slot.mem_read  = id_mem_read;
      id_slot.mem_acc   = id_mem_read | id_mem_write;
    end
  end

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                         input logic [REG_ADDR_W-1:0] src);
    if (hit(m, src, 1'b1) && !m.mem_read) return 2'b01;
    if (hit(w, src, 1'b1)) return 2'b10;
    return 2'b00;
  endfunction

  // Only a load directly ahead of its consumer needs a stall
  always_comb begin
    data_stall = id_valid && ex_q.mem_read &&
                 (hit(ex_q, id_rs1, id_use_rs1) || hit(ex_q, id_rs2, id_use_rs2));
    fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs1);
    fwd_b = fwd_sel(mem_q, wb_q, ex_q.rs2);
  end
`else
  // No bypass paths: hold ID until no producer remains in EX or MEM
  always_comb begin
    data_stall = id_valid &&
                 (hit(ex_q, id_rs1, id_use_rs1) || hit(ex_q, id_rs2, id_use_rs2) ||
                  hit(mem_q, id_rs1, id_use_rs1) || hit(mem_q, id_rs2, id_use_rs2));
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end
`endif

  // Some slot fields only matter in one build; fold them so they are not dangling
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

  // Freeze has priority over redirect, and redirect has priority over data stalls
  always_comb begin
    redirect   = !rst && !freeze && ex_redirect;
    hz_stall   = !rst && !freeze && !redirect && data_stall;
    stall_pc   = freeze || hz_stall;
    stall_ifid = freeze || hz_stall;
    flush_ifid = redirect;
    bubble_ex  = redirect || hz_stall;
  end

  // Request is dropped once the wait has timed out
  assign dmem_req = mem_q.valid && mem_q.mem_acc && !(state_q == ST_WAIT && mem_timeout);

  // Shadow slot advance: a frozen cycle holds EX/MEM and retires a bubble into WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (freeze) begin
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= bubble_ex ? BUBBLE : id_slot;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // D-cache wait FSM next state, wait counter and freeze
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = mem_timeout;
    freeze    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          freeze  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          freeze = 1'b1;
          if (cnt_q != CNT_W'(MEM_WAIT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (freeze && cnt_d == CNT_W'(MEM_WAIT_MAX)) timeout_d = 1'b1;
  end

  // D-cache FSM state, counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a scoreboard queue.
// The driver pushes the expected output vector for each cycle and the
// monitor compares it at the falling edge.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic       ex_redirect = 1'b0, dmem_ack = 1'b1;
  logic       stall_pc, stall_ifid, flush_ifid, bubble_ex, freeze;
  logic [1:0] fwd_a, fwd_b;
  logic       dmem_req, mem_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, mr, mw;
  } ins_t;

  typedef struct {
    logic [10:0] exp;
    string       nm;
  } sb_t;

  sb_t sb_q[$];

  pipeline_hazard_controller dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_redirect(ex_redirect), .dmem_ack(dmem_ack),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_ex(bubble_ex), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_req(dmem_req), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  wire [10:0] got = {stall_pc, stall_ifid, flush_ifid, bubble_ex, freeze,
                     fwd_a, fwd_b, dmem_req, mem_timeout};

  function automatic logic [10:0] ev(input logic spc, input logic sif, input logic fl,
                                     input logic bub, input logic frz, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic req, input logic to);
    return {spc, sif, fl, bub, frz, fa, fb, req, to};
  endfunction

  function automatic ins_t nop();
    return '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, u1: 1'b0, u2: 1'b0,
             rw: 1'b0, mr: 1'b0, mw: 1'b0};
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, u1: 1'b1, u2: 1'b1,
             rw: 1'b1, mr: 1'b0, mw: 1'b0};
  endfunction

  function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    return '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, u1: 1'b1, u2: 1'b0,
             rw: 1'b1, mr: 1'b1, mw: 1'b0};
  endfunction

  task automatic drv(input ins_t i, input logic redir, input logic ack, input logic r,
                     input logic [10:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rd        = i.rd;
    id_use_rs1   = i.u1;
    id_use_rs2   = i.u2;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    id_mem_write = i.mw;
    ex_redirect  = redir;
    dmem_ack     = ack;
    sb_q.push_back('{exp: exp, nm: nm});
  endtask

  task automatic step(input ins_t i, input logic [10:0] exp, input string nm);
    drv(i, 1'b0, 1'b1, 1'b0, exp, nm);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) step(nop(), '0, "drain");
  endtask

  // Monitor: compare the presented outputs against the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.nm, got, e.exp);
      end
    end
  end

  initial begin
    logic [10:0] z, st, st_req, fz, rq, rd, to_set;
    z      = '0;
    st     = ev(1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    st_req = ev(1, 1, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    fz     = ev(1, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0);
    rq     = ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    rd     = ev(0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    to_set = ev(1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1);

    // reset: redirect is masked and everything reads zero
    drv(alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1, z, "reset_redir");
    drv(nop(), 1'b0, 1'b1, 1'b1, z, "reset_hold");
    step(nop(), z, "after_reset");

    // add x5,x1,x2 ; sub x6,x5,x3
    step(alu(5'd5, 5'd1, 5'd2), z, "raw_add_id");
`ifdef FORWARDING_EN
    step(alu(5'd6, 5'd5, 5'd3), z, "raw_sub_id");
    step(nop(), ev(0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), "raw_fwd01");
`else
    step(alu(5'd6, 5'd5, 5'd3), st, "raw_stall_ex");
    step(alu(5'd6, 5'd5, 5'd3), st, "raw_stall_mem");
    step(alu(5'd6, 5'd5, 5'd3), z, "raw_release");
    step(nop(), z, "raw_sub_ex");
`endif
    drain();

    // lw x7,0(x1) ; add x8,x7,x7
    step(lw(5'd7, 5'd1), z, "lu_lw_id");
    step(alu(5'd8, 5'd7, 5'd7), st, "lu_stall");
`ifdef FORWARDING_EN
    step(alu(5'd8, 5'd7, 5'd7), rq, "lu_release");
    step(nop(), ev(0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0), "lu_fwd10");
`else
    step(alu(5'd8, 5'd7, 5'd7), st_req, "lu_stall_mem");
    step(alu(5'd8, 5'd7, 5'd7), z, "lu_release");
    step(nop(), z, "lu_add_ex");
`endif
    drain();

    // add x0,x1,x2 ; add x3,x0,x0 : x0 never hits
    step(alu(5'd0, 5'd1, 5'd2), z, "x0_prod");
    step(alu(5'd3, 5'd0, 5'd0), z, "x0_cons");
    step(nop(), z, "x0_ex");
    drain();

    // lw x9 waits three cycles in MEM; add x11 behind it must stay in EX
    step(lw(5'd9, 5'd1), z, "mw_lw_id");
    step(alu(5'd11, 5'd2, 5'd3), z, "mw_lw_ex");
    drv(nop(), 1'b0, 1'b0, 1'b0, fz, "mw_wait1");
    drv(lw(5'd7, 5'd1), 1'b1, 1'b0, 1'b0, fz, "mw_redir_ignored");
    drv(nop(), 1'b0, 1'b0, 1'b0, fz, "mw_wait3");
`ifdef FORWARDING_EN
    drv(alu(5'd12, 5'd11, 5'd0), 1'b0, 1'b1, 1'b0, rq, "mw_ack");
    step(nop(), ev(0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), "mw_ex_held_fwd");
`else
    drv(alu(5'd12, 5'd11, 5'd0), 1'b0, 1'b1, 1'b0, st_req, "mw_ack_ex_held");
    step(alu(5'd12, 5'd11, 5'd0), st, "mw_stall_mem");
    step(alu(5'd12, 5'd11, 5'd0), z, "mw_release");
`endif
    drain();

    // redirect overrides load-use, then a plain redirect
    step(lw(5'd7, 5'd1), z, "rd_lw_id");
    drv(alu(5'd8, 5'd7, 5'd7), 1'b1, 1'b1, 1'b0, rd, "rd_over_lu");
    step(nop(), rq, "rd_lw_mem");
    drv(nop(), 1'b1, 1'b1, 1'b0, rd, "rd_plain");
    drain();

    // timeout after 15 ack-low cycles, cleared by reset
    step(lw(5'd9, 5'd1), z, "to_lw_id");
    step(nop(), z, "to_lw_ex");
    for (int k = 0; k < 15; k++) drv(nop(), 1'b0, 1'b0, 1'b0, fz, "to_wait");
    drv(nop(), 1'b0, 1'b0, 1'b0, to_set, "to_set");
    drv(nop(), 1'b0, 1'b0, 1'b0, to_set, "to_sticky");
    drv(nop(), 1'b0, 1'b0, 1'b1, z, "to_reset");
    drv(nop(), 1'b0, 1'b0, 1'b0, z, "to_after_reset");

    for (int k = 0; k < 8 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
